// File: rtl/lfsr_share_arbiter.sv
// lfsr_share_arbiter: round-robin arbiter handing out words from one shared Fibonacci LFSR
module lfsr_share_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH = 8,
  parameter logic [WIDTH-1:0] TAPS = 8'hB8,
  parameter logic [WIDTH-1:0] RESET_SEED = 8'h01,
  parameter int ADV_STEPS = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enable,
  input  logic [NUM_REQ-1:0] req,
  input  logic               seed_load,
  input  logic [WIDTH-1:0]   seed_data,
  output logic [NUM_REQ-1:0] gnt,
  output logic [WIDTH-1:0]   rnd_data,
  output logic               busy,
  output logic               seed_err,
  output logic [WIDTH-1:0]   lfsr_state,
  output logic [15:0]        grant_cnt
);
  localparam int PW = $clog2(NUM_REQ);
  localparam int CW = $clog2(ADV_STEPS + 1);
  localparam logic [PW:0] NR = NUM_REQ[PW:0];
  typedef enum logic [1:0] {IDLE, GRANT, ADVANCE} state_t;
  state_t fsm, fsm_nx;
  logic [PW-1:0] ptr, off, win;
  logic [PW:0] sum;
  logic [NUM_REQ-1:0] rot;
  logic [CW-1:0] cnt, cnt_nx;
  logic go, shift;
  logic [WIDTH-1:0] lfsr_nx;
  // rotate requests so bit 0 is the current highest-priority requester, then map the winner back
  always_comb begin
    rot = NUM_REQ'({req, req} >> ptr);
    off = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) if (rot[i]) off = PW'(i);
    sum = {1'b0, ptr} + {1'b0, off};
    win = sum >= NR ? PW'(sum - NR) : PW'(sum);
  end
  // next state, step counter and LFSR update; seed_load overrides both shifting and arbitration
  always_comb begin
    fsm_nx = fsm;
    cnt_nx = cnt;
    go = 1'b0;
    shift = 1'b0;
    case (fsm)
      IDLE: go = enable && |req;
      GRANT: begin
        fsm_nx = ADVANCE;
        cnt_nx = CW'(ADV_STEPS);
      end
      ADVANCE: begin
        shift = 1'b1;
        cnt_nx = cnt - CW'(1);
        go = cnt == CW'(1) && enable && |req;
        fsm_nx = cnt == CW'(1) ? IDLE : ADVANCE;
      end
      default: fsm_nx = IDLE;
    endcase
    go = go && !seed_load;
    fsm_nx = seed_load ? IDLE : go ? GRANT : fsm_nx;
    lfsr_nx = seed_load ? (seed_data == '0 ? RESET_SEED : seed_data)
            : shift ? {lfsr_state[WIDTH-2:0], ^(lfsr_state & TAPS)} : lfsr_state;
  end
  // state and registered outputs; a grant delivers the word the LFSR holds during GRANT
  always_ff @(posedge clk) begin
    if (reset) begin
      fsm <= IDLE;
      cnt <= '0;
      ptr <= '0;
      lfsr_state <= RESET_SEED;
      gnt <= '0;
      rnd_data <= '0;
      busy <= 1'b0;
      seed_err <= 1'b0;
      grant_cnt <= '0;
    end else begin
      fsm <= fsm_nx;
      cnt <= cnt_nx;
      lfsr_state <= lfsr_nx;
      gnt <= go ? (NUM_REQ'(1) << win) : '0;
      busy <= fsm_nx != IDLE;
      seed_err <= seed_err | (seed_load && seed_data == '0);
      if (go) begin
        rnd_data <= lfsr_nx;
        grant_cnt <= grant_cnt + 16'd1;
        ptr <= win == PW'(NUM_REQ - 1) ? '0 : win + PW'(1);
      end
    end
  end
endmodule

// File: tb/tb_lfsr_share_arbiter.sv
// tb_lfsr_share_arbiter: scoreboard bench for two arbiters (ADV_STEPS 1 and 3) against a timestamp model
module tb_lfsr_share_arbiter;
  localparam int BIG = 1000;
  logic clk = 1'b0;
  logic reset, enable, seed_load;
  logic [3:0] req;
  logic [7:0] seed_data;
  logic [3:0] gnt_o [2];
  logic [7:0] rnd_o [2];
  logic [7:0] lfsr_o [2];
  logic busy_o [2];
  logic err_o [2];
  logic [15:0] cnt_o [2];
  int cyc = 0;
  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    int cyc;
    logic [3:0] gnt;
    logic [7:0] data;
    logic [15:0] cnt;
    logic [7:0] lfsr;
    logic err;
    logic busy;
  } exp_t;
  exp_t q0[$];
  exp_t q1[$];

  logic [7:0] m_st [2];
  logic [7:0] m_data [2];
  logic [15:0] m_cnt [2];
  logic m_err [2];
  int m_ptr [2];
  int m_age [2];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  lfsr_share_arbiter u_dut1 (
    .clk(clk), .reset(reset), .enable(enable), .req(req), .seed_load(seed_load),
    .seed_data(seed_data), .gnt(gnt_o[0]), .rnd_data(rnd_o[0]), .busy(busy_o[0]),
    .seed_err(err_o[0]), .lfsr_state(lfsr_o[0]), .grant_cnt(cnt_o[0])
  );

  lfsr_share_arbiter #(.ADV_STEPS(3)) u_dut3 (
    .clk(clk), .reset(reset), .enable(enable), .req(req), .seed_load(seed_load),
    .seed_data(seed_data), .gnt(gnt_o[1]), .rnd_data(rnd_o[1]), .busy(busy_o[1]),
    .seed_err(err_o[1]), .lfsr_state(lfsr_o[1]), .grant_cnt(cnt_o[1])
  );

  function automatic logic [7:0] lfsr_step(input logic [7:0] x);
    return {x[6:0], ^(x & 8'hB8)};
  endfunction

  // Model: m_age counts edges since the last grant. The LFSR shifts on edges 2..adv+1 after a
  // grant, a new grant may happen from edge adv+1 on, and a seed load cancels all of that.
  task automatic apply(input logic rst, input logic en, input logic [3:0] rq,
                       input logic sl, input logic [7:0] sd, output logic [3:0] g0);
    exp_t e;
    int adv, w;
    logic go, sh, bz;
    @(negedge clk);
    reset = rst; enable = en; req = rq; seed_load = sl; seed_data = sd;
    for (int k = 0; k < 2; k++) begin
      adv = (k == 1) ? 3 : 1;
      e.gnt = 4'b0000;
      bz = 1'b0;
      if (rst) begin
        m_st[k] = 8'h01; m_ptr[k] = 0; m_age[k] = BIG;
        m_cnt[k] = 16'd0; m_err[k] = 1'b0; m_data[k] = 8'h00;
      end else begin
        if (m_age[k] < BIG) m_age[k] = m_age[k] + 1;
        go = !sl && en && (rq != 4'b0000) && m_age[k] > adv;
        sh = !sl && m_age[k] >= 2 && m_age[k] <= adv + 1;
        bz = !sl && m_age[k] >= 1 && m_age[k] <= adv;
        m_st[k] = sl ? (sd != 8'h00 ? sd : 8'h01) : sh ? lfsr_step(m_st[k]) : m_st[k];
        m_err[k] = m_err[k] | (sl && sd == 8'h00);
        if (sl) m_age[k] = BIG;
        if (go) begin
          w = -1;
          for (int i = 0; i < 4; i++) if (w < 0 && rq[(m_ptr[k] + i) % 4]) w = (m_ptr[k] + i) % 4;
          e.gnt = 4'b0001 << w;
          m_data[k] = m_st[k];
          m_cnt[k] = m_cnt[k] + 16'd1;
          m_ptr[k] = (w + 1) % 4;
          m_age[k] = 0;
          bz = 1'b1;
        end
      end
      e.cyc = cyc + 1;
      e.data = m_data[k];
      e.cnt = m_cnt[k];
      e.lfsr = m_st[k];
      e.err = m_err[k];
      e.busy = bz;
      if (k == 0) begin
        q0.push_back(e);
        g0 = e.gnt;
      end else q1.push_back(e);
    end
  endtask

  task automatic chk(input int k, input exp_t e);
    vectors++;
    if (e.cyc != cyc || gnt_o[k] !== e.gnt || rnd_o[k] !== e.data || cnt_o[k] !== e.cnt ||
        lfsr_o[k] !== e.lfsr || err_o[k] !== e.err || busy_o[k] !== e.busy) begin
      miscompares++;
      $display("FAIL inst%0d cyc %0d/%0d: gnt=%b/%b rnd=%h/%h cnt=%0d/%0d lfsr=%h/%h err=%b/%b busy=%b/%b (got/exp)",
               k, cyc, e.cyc, gnt_o[k], e.gnt, rnd_o[k], e.data, cnt_o[k], e.cnt,
               lfsr_o[k], e.lfsr, err_o[k], e.err, busy_o[k], e.busy);
    end
  endtask

  always @(negedge clk) begin
    while (q0.size() > 0 && q0[0].cyc <= cyc) chk(0, q0.pop_front());
    while (q1.size() > 0 && q1[0].cyc <= cyc) chk(1, q1.pop_front());
  end

  initial begin
    logic [3:0] g;
    logic [3:0] pend;
    int r;
    reset = 1'b1; enable = 1'b0; req = 4'b0000; seed_load = 1'b0; seed_data = 8'h00;
    repeat (2) apply(1, 0, 4'b0000, 0, 8'h00, g);
    repeat (16) apply(0, 1, 4'b0100, 0, 8'h00, g);
    repeat (3) apply(0, 1, 4'b0000, 0, 8'h00, g);
    apply(1, 1, 4'b0000, 0, 8'h00, g);
    repeat (10) apply(0, 1, 4'b1111, 0, 8'h00, g);
    repeat (6) apply(0, 1, 4'b0000, 0, 8'h00, g);
    apply(0, 1, 4'b0001, 1, 8'h00, g);
    apply(0, 1, 4'b0001, 0, 8'h00, g);
    repeat (5) apply(0, 1, 4'b0000, 0, 8'h00, g);
    apply(1, 1, 4'b0000, 0, 8'h00, g);
    repeat (2) apply(0, 1, 4'b0010, 0, 8'h00, g);
    apply(0, 1, 4'b0010, 1, 8'h80, g);
    apply(0, 1, 4'b0010, 0, 8'h00, g);
    repeat (5) apply(0, 1, 4'b0000, 0, 8'h00, g);
    repeat (6) apply(0, 0, 4'b1111, 0, 8'h00, g);
    apply(0, 1, 4'b1111, 0, 8'h00, g);
    repeat (5) apply(0, 1, 4'b0000, 0, 8'h00, g);
    repeat (3) apply(0, 1, 4'b0100, 0, 8'h00, g);
    apply(1, 1, 4'b0100, 0, 8'h00, g);
    repeat (2) apply(0, 1, 4'b0000, 0, 8'h00, g);
    pend = 4'b0000;
    repeat (3000) begin
      r = $urandom_range(0, 99);
      for (int i = 0; i < 4; i++) begin
        if (!pend[i] && $urandom_range(0, 99) < 30) pend[i] = 1'b1;
        else if (pend[i] && $urandom_range(0, 99) < 3) pend[i] = 1'b0;
      end
      apply(r == 0, $urandom_range(0, 9) != 0, pend, $urandom_range(0, 19) == 0,
            $urandom_range(0, 3) == 0 ? 8'h00 : 8'($urandom), g);
      pend = pend & ~g;
    end
    repeat (3) @(negedge clk);
    #1;
    if (q0.size() != 0 || q1.size() != 0) begin
      miscompares++;
      $display("FAIL leftover: %0d/%0d expectations never checked, required 0", q0.size(), q1.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/lfsr_share_arbiter.md
Name: lfsr_share_arbiter

Overview:
- Shares one internal Fibonacci LFSR between NUM_REQ consumers, for example scramblers, test-pattern sources and random backoff timers.
- Grants go round-robin; each grant delivers the current LFSR word to one requester.
- After each grant the LFSR advances ADV_STEPS shifts, so consecutive consumers receive decorrelated words.
- A seed port loads a new start state; a zero seed is guarded against, because all-zero is the LFSR lock-up state.

Parameters:
- NUM_REQ, 4: number of requesters, 2..16.
- WIDTH, 8: LFSR width in bits, 3..32.
- TAPS, 8'hB8: feedback mask, WIDTH bits. Feedback = XOR-reduce(state & TAPS).
- RESET_SEED, 8'h01: LFSR state after reset and substitute for a zero seed. Must be nonzero.
- ADV_STEPS, 1: LFSR shifts performed after each grant. Must be ≥1.

Ports:
- clk, input, 1: clock.
- reset, input, 1: synchronous, active-high reset.
- enable, input, 1: high permits new grants.
- req, input, NUM_REQ: per-requester request, level. Held high until its gnt bit pulses.
- seed_load, input, 1: single-cycle strobe that loads seed_data.
- seed_data, input, WIDTH: new LFSR seed.
- gnt, output, NUM_REQ: one-hot grant, one-cycle pulse.
- rnd_data, output, WIDTH: word delivered with gnt. Holds the last granted word.
- busy, output, 1: high in GRANT or ADVANCE.
- seed_err, output, 1: sticky flag, set when a zero seed is loaded.
- lfsr_state, output, WIDTH: live LFSR register, for debug.
- grant_cnt, output, 16: total grants issued, wraps 0xFFFF→0x0000.

Behaviour:
- LFSR shift: state <= {state[WIDTH-2:0], ^(state & TAPS)}. The state never becomes zero.
- Reset values:
  - state = RESET_SEED; FSM = IDLE; gnt = 0; rnd_data = 0; busy = 0; seed_err = 0; grant_cnt = 0.
  - RR pointer = 0, so req[0] has highest priority first.
- All outputs are registered.
- FSM states:
  - IDLE: LFSR holds. If enable and |req, pick the winner round-robin starting at the RR pointer → GRANT.
  - GRANT, one cycle:
    - gnt[w] = 1 and rnd_data = state (the value before any shift).
    - grant_cnt += 1; RR pointer = w+1 mod NUM_REQ.
    - → ADVANCE with step counter = ADV_STEPS.
  - ADVANCE: shift once per cycle and decrement the counter.
    - On the final step, if enable and |req, arbitrate → GRANT directly.
    - Otherwise → IDLE.
- Latency: req sampled high in IDLE at edge t → gnt high in the cycle after edge t.
- Throughput: one grant per ADV_STEPS+1 cycles under continuous requests.
- Round-robin: the last winner has lowest priority on the next arbitration. With all req high the grant order is 0,1,2,…,NUM_REQ-1,0.
- Requesters must deassert req in the cycle after gnt, or they re-enter arbitration. A req dropped before its grant is never granted.
- enable low: no new arbitration. A GRANT or ADVANCE already in progress completes normally, then the FSM goes to IDLE.
- seed_load, accepted in any state:
  - Loads state = seed_data, or RESET_SEED if seed_data == 0; in the zero case seed_err is set.
  - Aborts ADVANCE and forces IDLE next cycle.
  - If seed_load coincides with GRANT, the grant still issues with the pre-load word and the load wins the state register.
  - In IDLE a seed_load blocks arbitration that cycle; the grant is deferred one cycle.
- grant_cnt wraps silently.
- Reset asserted mid-ADVANCE or mid-GRANT: all reset values take effect next cycle and no gnt is issued.

Test Plan:
- Reset, then a single requester with req[2] held high until gnt (default params, ADV_STEPS=1) → gnt=4'b0100 on successive grants. rnd_data sequence is 0x01, 0x02, 0x04, 0x08, 0x11, 0x23, 0x47, one grant every 2 cycles.
- All four req held high → grants 0,1,2,3,0 in order, each a one-cycle one-hot pulse. grant_cnt = 5.
- seed_load with seed_data=0x00 in IDLE → lfsr_state=0x01 and seed_err=1 (stays 1 until reset). No grant in that cycle.
- seed_load=0x80 during ADVANCE with req[1] pending → ADVANCE aborted, lfsr_state=0x80. Next grant goes to req[1] with rnd_data=0x80.
- enable low with req=4'b1111 → gnt stays 0 and lfsr_state is constant. Raising enable → gnt on the following cycle.
- ADV_STEPS=3, seed 0x01 → successive grants deliver 0x01, 0x08, 0x47. Reset pulsed mid-ADVANCE → lfsr_state=0x01 and grant_cnt=0.
